// File: rtl/fifo_rd_upsizer_pkg.sv
// Shared defaults for the FIFO read-side upsizer and its upstream FIFO.
package fifo_rd_upsizer_pkg;

   // Default upstream word width and packing ratio.
   localparam int DEF_IN_DWIDTH = 32;
   localparam int DEF_RATIO     = 2;

   // Default upstream FIFO depth.
   localparam int DEF_FIFO_DEPTH = 3;

endpackage

// File: rtl/fifo_0r1w.sv
// Small show-ahead FIFO: the head word is visible combinationally while
// o_empty is low, so a consumer can capture it in the same cycle it pops.
// Pushes while full are dropped; pops while empty are ignored.
module fifo_0r1w
   import fifo_rd_upsizer_pkg::*;
#(
   parameter int DEPTH  = DEF_FIFO_DEPTH,
   parameter int DWIDTH = DEF_IN_DWIDTH
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_push,
   input  logic [DWIDTH-1:0] i_wdata,
   output logic              o_full,
   input  logic              i_pop,
   output logic              o_empty,
   output logic [DWIDTH-1:0] o_rdata
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DWIDTH-1:0] mem_reg [DEPTH];
   logic [PW-1:0]     wr_ptr_reg;
   logic [PW-1:0]     rd_ptr_reg;
   logic [CW-1:0]     count_reg;
   logic              do_push;
   logic              do_pop;

   assign o_full  = (count_reg == CW'(DEPTH));
   assign o_empty = (count_reg == '0);
   assign o_rdata = mem_reg[rd_ptr_reg];
   assign do_push = i_push && !o_full;
   assign do_pop  = i_pop && !o_empty;

   // Storage writes; contents need no reset because count gates visibility.
   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= i_wdata;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap at DEPTH-1.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (do_pop && !do_push) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_rd_upsizer.sv
// Read-side width upsizer: pops RATIO narrow words from a show-ahead FIFO
// and presents them as one wide beat with a valid/ready handshake. A flush
// emits a partially filled beat with zeroed unused slots.
module fifo_rd_upsizer
   import fifo_rd_upsizer_pkg::*;
#(
   parameter int IN_DWIDTH = DEF_IN_DWIDTH,
   parameter int RATIO     = DEF_RATIO
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst,
   input  logic                                   i_fifo_empty,
   input  logic [IN_DWIDTH-1:0]                   i_fifo_rdata,
   output logic                                   o_fifo_pop,
   input  logic                                   i_flush,
   output logic                                   o_valid,
   input  logic                                   i_ready,
   output logic [IN_DWIDTH*RATIO-1:0]             o_data,
   output logic [$clog2(RATIO+1)-1:0]             o_nwords
);

   localparam int OUT_DWIDTH = IN_DWIDTH * RATIO;
   localparam int CNTW       = $clog2(RATIO + 1);

   typedef enum logic {
      FILL = 1'b0,
      OUT  = 1'b1
   } state_t;

   typedef logic [CNTW-1:0] count_t;

   state_t               state_reg;
   state_t               state_next;
   count_t               count_reg;
   count_t               count_next;
   count_t               count_after;
   count_t               nwords_reg;
   count_t               nwords_next;
   count_t               load_slot;
   logic                 load;
   logic                 clear;
   logic                 pop;
   logic [IN_DWIDTH-1:0] acc_reg [RATIO];

   // Pack the slot array into the wide beat, slot k at word position k.
   for (genvar gi = 0; gi < RATIO; gi++) begin : g_pack
      assign o_data[gi*IN_DWIDTH +: IN_DWIDTH] = acc_reg[gi];
   end

   assign o_fifo_pop = pop;
   assign o_valid    = (state_reg == OUT);
   assign o_nwords   = nwords_reg;

   // Pop decision, next-state and slot-write controls. In OUT a pop is only
   // taken alongside a handshake so the popped word seeds the next beat.
   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      nwords_next = nwords_reg;
      load        = 1'b0;
      load_slot   = '0;
      clear       = 1'b0;
      pop         = !i_fifo_empty && !i_rst && ((state_reg == FILL) || i_ready);
      count_after = count_reg + count_t'(pop);
      case (state_reg)
         FILL: begin
            if (pop) begin
               load      = 1'b1;
               load_slot = count_reg;
            end
            count_next = count_after;
            if (count_after == count_t'(RATIO)) begin
               state_next  = OUT;
               nwords_next = count_after;
            end else if (i_flush && (count_after != '0)) begin
               state_next  = OUT;
               nwords_next = count_after;
            end
         end
         OUT: begin
            if (i_ready) begin
               state_next  = FILL;
               nwords_next = '0;
               clear       = 1'b1;
               if (pop) begin
                  load       = 1'b1;
                  load_slot  = '0;
                  count_next = count_t'(1);
               end else begin
                  count_next = '0;
               end
            end
         end
         default: begin
            state_next = FILL;
         end
      endcase
   end

   // State, counters and accumulator slots. A clear wipes every slot when a
   // beat leaves, and a same-cycle load then overwrites slot 0.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg  <= FILL;
         count_reg  <= '0;
         nwords_reg <= '0;
         for (int i = 0; i < RATIO; i++) begin
            acc_reg[i] <= '0;
         end
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         nwords_reg <= nwords_next;
         for (int i = 0; i < RATIO; i++) begin
            if (load && (load_slot == count_t'(i))) begin
               acc_reg[i] <= i_fifo_rdata;
            end else if (clear) begin
               acc_reg[i] <= '0;
            end
         end
      end
   end

endmodule
